// File: rtl/sync_toggle_counter.sv
// sync_toggle_counter
// Count register plus the per-bit toggle vector for a bank of T flip-flops.
// The block supports up/down counting, parallel load, terminal-count detection
// and a saturating wrap counter.
// Optional feature macro: CNT_MODULO_EN.
//   - Defined: the count wraps at MOD-1, and loads above MOD-1 are clamped.
//   - Undefined: the count wraps naturally at 2^WIDTH-1, and loads pass through unchanged.
module sync_toggle_counter #(
   parameter int WIDTH = 4,
   parameter int MOD   = 10,
   parameter int WRAPW = 8
) (
   input  logic             clk,
   input  logic             rst,       // asynchronous, active-low
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic [WIDTH-1:0] toggle,
   output logic             tc,
   output logic [WRAPW-1:0] wrap_cnt
);

   // A modulus outside 2..2^WIDTH cannot be represented; stop at elaboration.
   if (MOD < 2 || MOD > (2 ** WIDTH)) begin : g_mod_out_of_range
      $error("sync_toggle_counter: MOD must satisfy 2 <= MOD <= 2^WIDTH");
   end

`ifdef CNT_MODULO_EN
   localparam logic [WIDTH-1:0] TOP = WIDTH'(MOD - 1);
`else
   localparam logic [WIDTH-1:0] TOP = '1;
`endif

   logic [WIDTH-1:0] count_q, count_d;
   logic [WRAPW-1:0] wrap_cnt_q, wrap_cnt_d;
   logic             tc_raw;

   // Next count: load beats enable; the enabled count wraps between TOP and 0.
   // NOTE: give every always_comb output a default first, so that no path leaves it unassigned and infers a latch.
   always_comb begin
      count_d = count_q;
      tc_raw  = 1'b0;
      if (load) begin
`ifdef CNT_MODULO_EN
         count_d = (load_val > TOP) ? TOP : load_val;
`else
         count_d = load_val;
`endif
      end else if (en) begin
         if (up) begin
            tc_raw  = (count_q == TOP);
            count_d = tc_raw ? '0 : count_q + WIDTH'(1);
         end else begin
            tc_raw  = (count_q == '0);
            count_d = tc_raw ? TOP : count_q - WIDTH'(1);
         end
      end
   end

   // Combinational outputs are held at zero while reset is asserted.
   always_comb begin
      toggle = rst ? (count_q ^ count_d) : '0;
      tc     = rst & tc_raw;
   end

   // The wrap counter counts terminal-count edges and saturates at all-ones.
   always_comb begin
      wrap_cnt_d = wrap_cnt_q;
      if (tc && (wrap_cnt_q != '1)) begin
         wrap_cnt_d = wrap_cnt_q + WRAPW'(1);
      end
   end

   // State registers with asynchronous active-low clear.
   // NOTE: use non-blocking (<=) in clocked blocks, so that every flop samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q    <= '0;
         wrap_cnt_q <= '0;
      end else begin
         count_q    <= count_d;
         wrap_cnt_q <= wrap_cnt_d;
      end
   end

   assign count    = count_q;
   assign wrap_cnt = wrap_cnt_q;

endmodule

// File: tb/tb_sync_toggle_counter.sv
// Randomized self-checking bench for sync_toggle_counter.
// The reference model works on plain integers with modular arithmetic.
// A second instance with WRAPW=2 exercises wrap-counter saturation.
module tb_sync_toggle_counter;

   localparam int WIDTH = 4;
   localparam int MOD   = 10;
`ifdef CNT_MODULO_EN
   localparam int TOP = MOD - 1;
`else
   localparam int TOP = (1 << WIDTH) - 1;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic             en, up, load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] count, toggle, count_s, toggle_s;
   logic             tc, tc_s;
   logic [7:0]       wrap_cnt;
   logic [1:0]       wrap_cnt_s;
   logic [WIDTH-1:0] shadow;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   int m_cnt, m_wrap, m_wrap_s;

   sync_toggle_counter #(.WIDTH(WIDTH), .MOD(MOD), .WRAPW(8)) dut (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
      .count(count), .toggle(toggle), .tc(tc), .wrap_cnt(wrap_cnt)
   );

   sync_toggle_counter #(.WIDTH(WIDTH), .MOD(MOD), .WRAPW(2)) dut_sat (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
      .count(count_s), .toggle(toggle_s), .tc(tc_s), .wrap_cnt(wrap_cnt_s)
   );

   always #5 clk = ~clk;

   // Shadow T flip-flop bank that is fed by toggle.
   always @(posedge clk or negedge rst) begin
      if (!rst) shadow <= '0;
      else      shadow <= shadow ^ toggle;
   end

   task automatic check(input string tag, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic int model_next(input int c);
      if (load)    return (int'(load_val) > TOP) ? TOP : int'(load_val);
      if (!en)     return c;
      if (up)      return (c + 1) % (TOP + 1);
      return (c + TOP) % (TOP + 1);
   endfunction

   function automatic bit model_tc(input int c);
      return en && !load && ((up && c == TOP) || (!up && c == 0));
   endfunction

   // One clock cycle:
   //   1. drive the inputs;
   //   2. check the combinational outputs;
   //   3. advance to the next edge;
   //   4. check the registered outputs.
   task automatic cycle(input bit e, input bit u, input bit l, input int lv);
      int nxt;
      bit t;
      en = e; up = u; load = l; load_val = WIDTH'(lv);
      #1;
      nxt = model_next(m_cnt);
      t   = model_tc(m_cnt);
      check("toggle", int'(toggle), m_cnt ^ nxt);
      check("tc", int'(tc), int'(t));
      @(posedge clk);
      m_cnt = nxt;
      if (t) begin
         if (m_wrap < 255) m_wrap++;
         if (m_wrap_s < 3) m_wrap_s++;
      end
      #1;
      check("count", int'(count), m_cnt);
      check("wrap_cnt", int'(wrap_cnt), m_wrap);
      check("wrap_cnt_sat", int'(wrap_cnt_s), m_wrap_s);
      check("shadow_tff", int'(shadow), int'(count));
   endtask

   task automatic check_reset_zero();
      check("rst_count", int'(count), 0);
      check("rst_wrap", int'(wrap_cnt), 0);
      check("rst_toggle", int'(toggle), 0);
      check("rst_tc", int'(tc), 0);
   endtask

   initial begin
      rst = 1'b0; en = 1'b1; up = 1'b1; load = 1'b0; load_val = '0;
      m_cnt = 0; m_wrap = 0; m_wrap_s = 0;
      #1;
      check_reset_zero();
      @(posedge clk);
      #1;
      check_reset_zero();
      #2 rst = 1'b1;

      // Count up through more than one wrap.
      for (int i = 0; i < 20; i++) cycle(1, 1, 0, 0);

      // Load zero, then count down across the wrap point.
      cycle(0, 0, 1, 0);
      for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0);

      // Load 13 with the enable active: the load wins, and tc is suppressed.
      cycle(1, 1, 1, 13);
      for (int i = 0; i < 5; i++) cycle(1, 1, 0, 0);

      // Hold at count 6.
      cycle(0, 1, 1, 6);
      for (int i = 0; i < 5; i++) cycle(0, $urandom_range(0, 1), 0, 0);

      // Direction changes on consecutive edges.
      cycle(1, 1, 0, 0);
      cycle(1, 0, 0, 0);
      cycle(1, 0, 0, 0);
      cycle(1, 1, 0, 0);

      // Five full up-wraps, which drives the 2-bit wrap counter into saturation.
      for (int i = 0; i < 5 * (TOP + 1); i++) cycle(1, 1, 0, 0);

      // Assert an asynchronous reset mid-cycle at count 7.
      cycle(0, 1, 1, 7);
      #3 rst = 1'b0;
      m_cnt = 0; m_wrap = 0; m_wrap_s = 0;
      #1;
      check_reset_zero();
      @(posedge clk);
      #1;
      check_reset_zero();
      #2 rst = 1'b1;

      // Random traffic; load is asserted rarely.
      for (int i = 0; i < 150; i++) begin
         cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1),
               $urandom_range(0, 9) == 0, $urandom_range(0, 15));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sync_toggle_counter.md
# sync_toggle_counter

- Upstream toggle-generation and state stage for the team's synchronous T-flip-flop counters.
- Holds a WIDTH-bit count and computes, every cycle, the per-bit toggle vector that a bank of T flip-flops needs to reach the next count value.
- Supports up/down counting, parallel load, terminal-count detection and a wrap counter.
- Sits directly in front of the T-FF bank; the bank's T inputs connect to `toggle`.

## Interface
Parameters:
- `WIDTH`, 4: count width in bits (≥2).
- `MOD`, 10: modulus, 2 ≤ MOD ≤ 2^WIDTH. Only used when `CNT_MODULO_EN` is defined.
- `WRAPW`, 8: width of the wrap counter.

Ports:
- `clk` input 1: clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `en` input 1: count enable.
- `up` input 1: direction; 1 = increment, 0 = decrement.
- `load` input 1: synchronous parallel load; has priority over `en`.
- `load_val` input WIDTH: value loaded when `load`=1.
- `count` output WIDTH: registered present count.
- `toggle` output WIDTH: combinational; equals `count` XOR next count.
- `tc` output 1: combinational terminal-count flag.
- `wrap_cnt` output WRAPW: registered number of wraps, saturating.

## Operation
- Top value TOP is MOD−1 when `CNT_MODULO_EN` is defined, otherwise 2^WIDTH−1.
- Next-count priority:
  - `load`: next = `load_val`; clamped to TOP if `load_val` > TOP.
  - else `en` & `up`: next = 0 if count == TOP, else count+1.
  - else `en` & !`up`: next = TOP if count == 0, else count−1.
  - else: next = count (hold).
- `toggle` = count ^ next. It is 0 whenever holding or loading the current value.
  - A T-FF bank reset together with this block, and fed `toggle`, tracks `count` exactly.
- `tc` = `en` & !`load` & ((`up` & count==TOP) | (!`up` & count==0)).
- Wrap counter:
  - `wrap_cnt` increments on every clock edge where `tc`=1.
  - Saturates at 2^WRAPW−1.
  - Not affected by `load`.
- Arithmetic is unsigned, modulo as above. Intermediate values are never wider than WIDTH, except for the clamp comparison.

## Timing
- Reset, asynchronous on `rst`=0:
  - `count`=0 and `wrap_cnt`=0 immediately.
  - `toggle`=0 and `tc`=0 follow while `rst`=0; combinational outputs are forced to 0 during reset.
- Reset release is synchronous to the next rising edge; the first count update happens on the first edge with `rst`=1.
- Latency:
  - `count` reflects an input decision one clock after it is sampled.
  - `toggle` and `tc` are valid in the same cycle as their inputs, with zero latency.
- Simultaneous `load` and `en`: load wins and `tc` is suppressed, so no wrap is counted.
- Direction change: takes effect on the same edge; no dead cycle.
- Reset mid-count: count is lost and `wrap_cnt` is cleared; there is no pending-state retention.

## Configuration
- `CNT_MODULO_EN`
  - Defined: modulus MOD is enforced (TOP = MOD−1) and loads above TOP are clamped.
  - Undefined: natural binary wrap at 2^WIDTH−1 and `MOD` is ignored. No clamp logic; any `load_val` is loaded unchanged.

## Test plan
All scenarios use WIDTH=4, MOD=10, `CNT_MODULO_EN` defined unless stated.
- Reset then `en`=1, `up`=1 for 12 clocks:
  - `count` goes 1..9, 0, 1, 2.
  - `tc`=1 while count=9; `toggle`=4'b1001 at count 9.
  - `wrap_cnt`=1.
- `up`=0 from count 0:
  - next count=9, `toggle`=4'b1001, `tc`=1, `wrap_cnt` increments.
  - Then 8, 7 with `toggle`=4'b0001, 4'b1111.
- `load`=1, `load_val`=13 with `en`=1:
  - `count`=9 next cycle, `tc`=0, `wrap_cnt` unchanged.
  - With `CNT_MODULO_EN` undefined: `count`=13, and counting up wraps 15→0 with `tc`=1.
- `en`=0 for 5 clocks at count 6: `count` stays 6, `toggle`=0, `tc`=0.
- Assert `rst`=0 asynchronously mid-cycle at count 7:
  - `count`=0 and `wrap_cnt`=0 immediately, without waiting for an edge.
  - A shadow T-FF bank driven by `toggle` matches `count` over 100 random cycles.
- WRAPW=2, 5 full up-wraps: `wrap_cnt` saturates at 3.
